// File: rtl/serial_add_unit_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and the default width.
package serial_add_unit_pkg;

  localparam int SA_WIDTH_DEFAULT = 8;
  localparam int SA_WIDTH_MIN     = 2;
  localparam int SA_WIDTH_MAX     = 32;

  // 2'b11 is unused and decodes back to IDLE in the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } sa_state_t;

endpackage

// File: rtl/serial_add_unit_full_add_cell.sv
// Gate-level one-bit adder: two half-adder stages whose carries are ORed into Cout.
module half_add_cell (
  input  logic A,
  input  logic B,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B;
  assign Cout = A & B;

endmodule

module full_add_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_add_cell u_ha0 (
    .A    (A),
    .B    (B),
    .Sum  (w_s1),
    .Cout (w_c1)
  );

  half_add_cell u_ha1 (
    .A    (w_s1),
    .B    (Cin),
    .Sum  (Sum),
    .Cout (w_c2)
  );

  // The two half-adder carries can never both be 1, so OR gives the majority.
  assign Cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial unsigned adder: operands shifted LSB-first through one full-adder cell,
// carry held in a flip-flop between bits, Start/Busy/Done handshake.
module serial_add_unit
  import serial_add_unit_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Busy,
  output logic             Done
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_t        r_state;
  sa_state_t        w_state_next;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_load;
  logic             w_run;
  logic             w_last;
  logic             w_s;
  logic             w_co;

  full_add_cell u_fa (
    .A    (r_sha[0]),
    .B    (r_shb[0]),
    .Cin  (r_carry),
    .Sum  (w_s),
    .Cout (w_co)
  );

  assign w_run  = (r_state == ST_RUN);
  assign w_last = w_run && (r_cnt == LAST_BIT);
  // Start is only honoured from IDLE or DONE; an add in RUN cannot be disturbed.
  assign w_load = Start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_state_next = ST_DONE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_sha   <= '0;
      r_shb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_sha   <= A;
      r_shb   <= B;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_sha   <= {1'b0, r_sha[WIDTH-1:1]};
      r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_co;
      // Counter parks at zero after the final bit so it never passes WIDTH-1.
      if (w_last) begin
        r_cout <= w_co;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Busy = w_run;
  assign Done = (r_state == ST_DONE);

endmodule
